// File: rtl/l1_trig_encoder.sv
// L1 trigger encoder: masks per-beam triggers, coalesces them over a short window into
// timestamped messages, enforces a holdoff, and queues messages in a FWFT FIFO.
module l1_trig_encoder #(
  parameter int NBEAMS     = 48,
  parameter int WINDOW     = 4,
  parameter int HOLDOFF    = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int TS_BITS    = 16
) (
  input  logic               ifclk,
  input  logic               rst_i,
  input  logic [NBEAMS-1:0]  trig_i,
  input  logic [NBEAMS-1:0]  mask_i,
  input  logic               enable_i,
  input  logic               ts_rst_i,
  output logic               trig_valid_o,
  input  logic               trig_ready_i,
  output logic [NBEAMS-1:0]  trig_beams_o,
  output logic [TS_BITS-1:0] trig_time_o,
  output logic [15:0]        dropped_o,
  output logic               busy_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(WINDOW + HOLDOFF + 2);
  localparam int MW = NBEAMS + TS_BITS;
  localparam logic [CW-1:0] WIN_LAST  = CW'(WINDOW - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLDOFF - 1);
  localparam logic [PW:0]   DEPTH     = (PW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, HOLD = 2'd2} state_t;
  localparam state_t END_STATE = (HOLDOFF > 0) ? HOLD : IDLE;

  state_t state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [NBEAMS-1:0] q, beams, beams_next, push_beams;
  logic [TS_BITS-1:0] ts, win_time, win_time_next, push_time;
  logic open_win, push;

  logic [MW-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr, rd_ptr_next;
  logic [PW:0] count, count_next, after_pop;
  logic [MW-1:0] head_next;
  logic pop, full, wr_en, drop;

  assign q        = trig_i & ~mask_i;
  assign open_win = enable_i & (|q);

  // Free-running timestamp with synchronous clear.
  always_ff @(posedge ifclk) begin
    if (rst_i || ts_rst_i) ts <= '0;
    else ts <= ts + TS_BITS'(1'b1);
  end

  // FSM state register, window/holdoff counter and the message being built.
  always_ff @(posedge ifclk) begin
    if (rst_i) begin
      state    <= IDLE;
      cnt      <= '0;
      beams    <= '0;
      win_time <= '0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      beams    <= beams_next;
      win_time <= win_time_next;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (open_win) begin
          if (WINDOW > 1) begin
            state_next = ACCUM;
            cnt_next   = CW'(1'b1);
          end else begin
            state_next = END_STATE;
            cnt_next   = '0;
          end
        end else begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      end
      ACCUM: begin
        if (cnt == WIN_LAST) begin
          state_next = END_STATE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CW'(1'b1);
        end
      end
      HOLD: begin
        if (cnt == HOLD_LAST) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CW'(1'b1);
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // FSM outputs: beam accumulation and the message push at the last window cycle.
  always_comb begin
    push          = 1'b0;
    push_beams    = beams | q;
    push_time     = win_time;
    beams_next    = beams;
    win_time_next = win_time;
    case (state)
      IDLE: begin
        if (open_win) begin
          beams_next    = q;
          win_time_next = ts;
          if (WINDOW == 1) begin
            push       = 1'b1;
            push_beams = q;
            push_time  = ts;
          end else begin
            push = 1'b0;
          end
        end else begin
          beams_next = beams;
        end
      end
      ACCUM: begin
        beams_next = beams | q;
        if (cnt == WIN_LAST) push = 1'b1;
        else push = 1'b0;
      end
      HOLD:    push = 1'b0;
      default: push = 1'b0;
    endcase
  end

  // A push into a full FIFO still lands if the head leaves in the same cycle.
  assign pop         = trig_valid_o & trig_ready_i;
  assign full        = (count == DEPTH);
  assign wr_en       = push & (~full | pop);
  assign drop        = push & full & ~pop;
  assign after_pop   = count - (PW + 1)'(pop);
  assign count_next  = after_pop + (PW + 1)'(wr_en);
  assign rd_ptr_next = rd_ptr + PW'(pop);

  // Next head: zero when empty, bypass the pushed word when it becomes the head.
  always_comb begin
    head_next = '0;
    if (count_next == '0) head_next = '0;
    else if (after_pop == '0) head_next = {push_beams, push_time};
    else head_next = mem[rd_ptr_next];
  end

  // FIFO storage.
  always_ff @(posedge ifclk) begin
    if (wr_en) mem[wr_ptr] <= {push_beams, push_time};
  end

  // FIFO pointers, registered head/valid, drop counter and busy flag.
  always_ff @(posedge ifclk) begin
    if (rst_i) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      trig_valid_o <= 1'b0;
      trig_beams_o <= '0;
      trig_time_o  <= '0;
      dropped_o    <= 16'd0;
      busy_o       <= 1'b0;
    end else begin
      rd_ptr       <= rd_ptr_next;
      wr_ptr       <= wr_en ? wr_ptr + PW'(1'b1) : wr_ptr;
      count        <= count_next;
      trig_valid_o <= (count_next != '0);
      {trig_beams_o, trig_time_o} <= head_next;
      if (drop && dropped_o != 16'hFFFF) dropped_o <= dropped_o + 16'd1;
      busy_o       <= (state_next != IDLE);
    end
  end

endmodule
